// File: rtl/color_manager.sv
// color_manager - assembles quadrant colours from RX bytes, forwards them to the colour store
// and drives the VGA pixel colour for the current screen quadrant.
module color_manager #(
   parameter int UART_DATA_WIDTH           = 8,
   parameter int C_ADDR_WIDTH              = 2,
   parameter int C_DATA_WIDTH              = 10,
   parameter int DATA_WIDTH                = 10,
   parameter int CONFIG_STATUS_WIDTH       = 2,
   parameter int CONFIG_NOTIFICATION_WIDTH = 2,
   parameter int CONFIG_ERROR_WIDTH        = 2,
   parameter int VGA_NOTIFICATION_WIDTH    = 2,
   parameter int CNT_WIDTH                 = 12,
   parameter int H_HALF                    = 320,
   parameter int V_HALF                    = 240
) (
   input  logic                                 Clk,
   input  logic                                 Rst,
   input  logic                                 Empty,
   input  logic [UART_DATA_WIDTH-1:0]           RXD_Data,
   input  logic                                 C_Rdy,
   input  logic                                 Vertical_Split,
   input  logic                                 Horizontal_Split,
   input  logic                                 VGA_Debugg,
   input  logic                                 HSync,
   input  logic                                 VSync,
   output logic [C_ADDR_WIDTH-1:0]              C_Addr,
   output logic [C_DATA_WIDTH-1:0]              C_Data,
   output logic                                 C_Valid,
   output logic [CONFIG_STATUS_WIDTH-1:0]       Config_Status,
   output logic [CONFIG_NOTIFICATION_WIDTH-1:0] Config_Notification,
   output logic                                 Config_Notification_Valid,
   output logic [CONFIG_ERROR_WIDTH-1:0]        Config_Error,
   output logic                                 Error_Valid,
   output logic [VGA_NOTIFICATION_WIDTH-1:0]    VGA_Notification,
   output logic                                 VGA_Notification_Valid,
   output logic [DATA_WIDTH-1:0]                Data_VGA
);

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      WAIT_DATA = 2'b01,
      SEND      = 2'b10
   } state_t;

   localparam logic [1:0] TAG_HDR  = 2'b00;
   localparam logic [1:0] TAG_DATA = 2'b01;
   localparam logic [1:0] ERR_IDLE = 2'b01;
   localparam logic [1:0] ERR_WAIT = 2'b10;
   localparam logic [1:0] ERR_SEND = 2'b11;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   state_t                         state_q;
   logic [C_ADDR_WIDTH-1:0]        hdr_addr_q;
   logic [3:0]                     hdr_nib_q;
   logic [C_ADDR_WIDTH-1:0]        c_addr_q;
   logic [C_DATA_WIDTH-1:0]        c_data_q;
   logic                           c_valid_q;
   logic [CONFIG_NOTIFICATION_WIDTH-1:0] notif_q;
   logic                           notif_valid_q;
   logic [CONFIG_ERROR_WIDTH-1:0]  err_q;
   logic                           err_valid_q;
   logic [C_DATA_WIDTH-1:0]        colour_q [4];

   logic                           byte_ok;
   logic [1:0]                     tag;

   assign byte_ok = ~Empty;
   assign tag     = RXD_Data[7:6];

   // Configuration FSM; all of its outputs are registered here.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q       <= IDLE;
         hdr_addr_q    <= '0;
         hdr_nib_q     <= '0;
         c_addr_q      <= '0;
         c_data_q      <= '0;
         c_valid_q     <= 1'b0;
         notif_q       <= '0;
         notif_valid_q <= 1'b0;
         err_q         <= '0;
         err_valid_q   <= 1'b0;
         for (int i = 0; i < 4; i++) colour_q[i] <= '0;
      end else begin
         err_valid_q   <= 1'b0;
         notif_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (byte_ok) begin
                  if (tag == TAG_HDR) begin
                     hdr_addr_q <= RXD_Data[5:4];
                     hdr_nib_q  <= RXD_Data[3:0];
                     state_q    <= WAIT_DATA;
                  end else begin
                     err_valid_q <= 1'b1;
                     err_q       <= ERR_IDLE;
                  end
               end
            end
            WAIT_DATA: begin
               if (byte_ok) begin
                  if (tag == TAG_DATA) begin
                     c_addr_q  <= hdr_addr_q;
                     c_data_q  <= {hdr_nib_q, RXD_Data[5:0]};
                     c_valid_q <= 1'b1;
                     state_q   <= SEND;
                  end else begin
                     err_valid_q <= 1'b1;
                     err_q       <= ERR_WAIT;
                     state_q     <= IDLE;
                  end
               end
            end
            SEND: begin
               // A byte arriving while the store handshake is pending is lost.
               if (byte_ok) begin
                  err_valid_q <= 1'b1;
                  err_q       <= ERR_SEND;
               end
               if (C_Rdy) begin
                  colour_q[c_addr_q] <= c_data_q;
                  c_valid_q          <= 1'b0;
                  notif_q            <= c_addr_q;
                  notif_valid_q      <= 1'b1;
                  state_q            <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   logic                           hs_q, vs_q;
   logic [CNT_WIDTH-1:0]           h_cnt_q, h_cnt_d;
   logic [CNT_WIDTH-1:0]           v_cnt_q, v_cnt_d;
   logic                           vsplit_q, hsplit_q, dbg_q;
   logic [VGA_NOTIFICATION_WIDTH-1:0] vga_n_q, vga_n_d;
   logic                           vga_nv_q, vga_nv_d;
   logic [DATA_WIDTH-1:0]          data_vga_q, data_vga_d;
   logic                           hs_rise, vs_rise;
   logic [1:0]                     quad;

   assign hs_rise = HSync & ~hs_q;
   assign vs_rise = VSync & ~vs_q;

   always_comb begin
      h_cnt_d    = h_cnt_q;
      v_cnt_d    = v_cnt_q;
      vga_n_d    = vga_n_q;
      vga_nv_d   = 1'b0;
      quad       = '0;
      data_vga_d = '0;

      if (hs_rise)               h_cnt_d = '0;
      else if (h_cnt_q != CNT_MAX) h_cnt_d = h_cnt_q + 1'b1;

      if (vs_rise)                          v_cnt_d = '0;
      else if (hs_rise && v_cnt_q != CNT_MAX) v_cnt_d = v_cnt_q + 1'b1;

      quad[0] = Vertical_Split   & (h_cnt_q >= CNT_WIDTH'(H_HALF));
      quad[1] = Horizontal_Split & (v_cnt_q >= CNT_WIDTH'(V_HALF));

      if (VGA_Debugg) data_vga_d = DATA_WIDTH'({5{quad}});
      else            data_vga_d = DATA_WIDTH'(colour_q[quad]);

      if ((Vertical_Split != vsplit_q) || (Horizontal_Split != hsplit_q) ||
          (VGA_Debugg != dbg_q)) begin
         vga_nv_d = 1'b1;
         vga_n_d  = VGA_NOTIFICATION_WIDTH'({Horizontal_Split, Vertical_Split});
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         hs_q       <= 1'b0;
         vs_q       <= 1'b0;
         h_cnt_q    <= '0;
         v_cnt_q    <= '0;
         vsplit_q   <= 1'b0;
         hsplit_q   <= 1'b0;
         dbg_q      <= 1'b0;
         vga_n_q    <= '0;
         vga_nv_q   <= 1'b0;
         data_vga_q <= '0;
      end else begin
         hs_q       <= HSync;
         vs_q       <= VSync;
         h_cnt_q    <= h_cnt_d;
         v_cnt_q    <= v_cnt_d;
         vsplit_q   <= Vertical_Split;
         hsplit_q   <= Horizontal_Split;
         dbg_q      <= VGA_Debugg;
         vga_n_q    <= vga_n_d;
         vga_nv_q   <= vga_nv_d;
         data_vga_q <= data_vga_d;
      end
   end

   assign C_Addr                    = c_addr_q;
   assign C_Data                    = c_data_q;
   assign C_Valid                   = c_valid_q;
   assign Config_Status             = CONFIG_STATUS_WIDTH'(state_q);
   assign Config_Notification       = notif_q;
   assign Config_Notification_Valid = notif_valid_q;
   assign Config_Error              = err_q;
   assign Error_Valid               = err_valid_q;
   assign VGA_Notification          = vga_n_q;
   assign VGA_Notification_Valid    = vga_nv_q;
   assign Data_VGA                  = data_vga_q;

endmodule

// File: tb/tb_color_manager.sv
// tb/tb_color_manager.sv - directed self-checking bench for color_manager
module tb_color_manager;

   logic       Clk = 1'b0;
   logic       Rst = 1'b1;
   logic       Empty = 1'b1;
   logic [7:0] RXD_Data = '0;
   logic       C_Rdy = 1'b0;
   logic       Vertical_Split = 1'b0;
   logic       Horizontal_Split = 1'b0;
   logic       VGA_Debugg = 1'b0;
   logic       HSync = 1'b0;
   logic       VSync = 1'b0;
   logic [1:0] C_Addr;
   logic [9:0] C_Data;
   logic       C_Valid;
   logic [1:0] Config_Status;
   logic [1:0] Config_Notification;
   logic       Config_Notification_Valid;
   logic [1:0] Config_Error;
   logic       Error_Valid;
   logic [1:0] VGA_Notification;
   logic       VGA_Notification_Valid;
   logic [9:0] Data_VGA;

   int tests = 0;
   int fails = 0;

   color_manager dut (
      .Clk(Clk), .Rst(Rst), .Empty(Empty), .RXD_Data(RXD_Data), .C_Rdy(C_Rdy),
      .Vertical_Split(Vertical_Split), .Horizontal_Split(Horizontal_Split),
      .VGA_Debugg(VGA_Debugg), .HSync(HSync), .VSync(VSync),
      .C_Addr(C_Addr), .C_Data(C_Data), .C_Valid(C_Valid),
      .Config_Status(Config_Status), .Config_Notification(Config_Notification),
      .Config_Notification_Valid(Config_Notification_Valid),
      .Config_Error(Config_Error), .Error_Valid(Error_Valid),
      .VGA_Notification(VGA_Notification), .VGA_Notification_Valid(VGA_Notification_Valid),
      .Data_VGA(Data_VGA)
   );

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      Empty = 1'b0;
      RXD_Data = b;
      tick();
      Empty = 1'b1;
   endtask

   task automatic hs_rise();
      HSync = 1'b1;
      tick();
      HSync = 1'b0;
   endtask

   initial begin
      // 1: reset, header 0x0A + data 0x5A, store not ready
      tick(); tick();
      chk("rst_cvalid", C_Valid, 0);
      chk("rst_status", Config_Status, 0);
      chk("rst_data_vga", Data_VGA, 0);
      chk("rst_err_valid", Error_Valid, 0);
      Rst = 1'b0;
      tick();
      send_byte(8'h0A);
      chk("t1_status_wait", Config_Status, 2'b01);
      send_byte(8'h5A);
      chk("t1_cvalid", C_Valid, 1);
      chk("t1_caddr", C_Addr, 0);
      chk("t1_cdata", C_Data, 10'h29A);
      chk("t1_status_send", Config_Status, 2'b10);
      tick(); tick();
      chk("t1_cvalid_held", C_Valid, 1);
      chk("t1_cdata_held", C_Data, 10'h29A);
      C_Rdy = 1'b1;
      tick();
      chk("t1_cvalid_drop", C_Valid, 0);
      chk("t1_notif_valid", Config_Notification_Valid, 1);
      chk("t1_notif", Config_Notification, 0);
      chk("t1_status_idle", Config_Status, 0);
      tick();
      chk("t1_notif_pulse", Config_Notification_Valid, 0);
      chk("t1_data_vga", Data_VGA, 10'h29A);

      // 2: store already ready
      send_byte(8'h1A);
      send_byte(8'h5F);
      chk("t2_cvalid", C_Valid, 1);
      chk("t2_caddr", C_Addr, 2'b01);
      chk("t2_cdata", C_Data, 10'h29F);
      tick();
      chk("t2_cvalid_one", C_Valid, 0);
      chk("t2_notif_valid", Config_Notification_Valid, 1);
      chk("t2_notif", Config_Notification, 2'b01);

      // 3: colour for RD, then a broken header/data pair
      send_byte(8'h3A);
      send_byte(8'h50);
      chk("t3_caddr", C_Addr, 2'b11);
      chk("t3_cdata", C_Data, 10'h290);
      tick();
      chk("t3_notif", Config_Notification, 2'b11);
      send_byte(8'h2A);
      send_byte(8'h00);
      chk("t3_err_valid", Error_Valid, 1);
      chk("t3_err_code", Config_Error, 2'b10);
      chk("t3_no_cvalid", C_Valid, 0);
      chk("t3_status_idle", Config_Status, 0);
      tick();
      chk("t3_err_pulse", Error_Valid, 0);
      chk("t3_err_hold", Config_Error, 2'b10);

      // 4: both splits on, walk the four quadrants
      Vertical_Split = 1'b1;
      Horizontal_Split = 1'b1;
      tick();
      chk("t4_vga_nv", VGA_Notification_Valid, 1);
      chk("t4_vga_n", VGA_Notification, 2'b11);
      tick();
      chk("t4_vga_nv_pulse", VGA_Notification_Valid, 0);
      VSync = 1'b1; tick(); VSync = 1'b0; tick();
      hs_rise();
      repeat (320) tick();
      chk("t4_lu_edge", Data_VGA, 10'h29A);
      tick();
      chk("t4_ru_edge", Data_VGA, 10'h29F);
      for (int i = 0; i < 238; i++) begin
         hs_rise();
         tick();
      end
      hs_rise();
      repeat (20) tick();
      chk("t4_ld", Data_VGA, 10'h000);
      repeat (301) tick();
      chk("t4_rd", Data_VGA, 10'h290);

      // 5: bad tag in IDLE, then a byte during SEND
      send_byte(8'h8A);
      chk("t5_err_idle_valid", Error_Valid, 1);
      chk("t5_err_idle_code", Config_Error, 2'b01);
      chk("t5_err_idle_status", Config_Status, 0);
      C_Rdy = 1'b0;
      send_byte(8'h0A);
      send_byte(8'h55);
      chk("t5_cdata", C_Data, 10'h295);
      send_byte(8'h1B);
      chk("t5_err_send_valid", Error_Valid, 1);
      chk("t5_err_send_code", Config_Error, 2'b11);
      chk("t5_cdata_kept", C_Data, 10'h295);
      chk("t5_status_send", Config_Status, 2'b10);
      chk("t5_cvalid_kept", C_Valid, 1);

      // 6: asynchronous reset while in SEND, then debug pattern
      #2 Rst = 1'b1;
      #1;
      chk("t6_cvalid_async", C_Valid, 0);
      chk("t6_status_async", Config_Status, 0);
      chk("t6_cdata_async", C_Data, 0);
      chk("t6_data_vga_async", Data_VGA, 0);
      tick();
      VGA_Debugg = 1'b1;
      Rst = 1'b0;
      tick();
      chk("t6_vga_nv", VGA_Notification_Valid, 1);
      chk("t6_vga_n", VGA_Notification, 2'b11);
      chk("t6_dbg_q0", Data_VGA, 10'h000);
      repeat (321) tick();
      chk("t6_dbg_q1", Data_VGA, 10'h155);
      C_Rdy = 1'b1;
      send_byte(8'h0A);
      send_byte(8'h55);
      tick(); tick();
      chk("t6_dbg_overrides_colour", Data_VGA, 10'h155);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
